rx_mtrp_adapt: RTL and testbench

- Parametrised successor to the fixed 12-bit MTRP receiver: adaptive three-level (bipolar/AMI) line receiver for ADC samples.
- Tracks windowed peak/trough, derives mid-level and positive/negative slicing thresholds, and slices marks into RXP/RXN.
- Adds an acquisition/lock state machine, loss-of-signal detection and bipolar-violation counting.
- Sits directly after the ADC/MTRP generator sample path and shares its ce sample strobe.

---
 rtl/mtrp_pkg.sv | 20 ++
 rtl/mtrp_peak_win.sv | 85 ++++++++
 rtl/rx_mtrp_adapt.sv | 122 ++++++++++++
 tb/tb_rx_mtrp_adapt.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mtrp_pkg.sv
// Shared types and default parameters for the adaptive bipolar MTRP receiver.
package mtrp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    typedef enum logic {
        POL_P = 1'b0,
        POL_N = 1'b1
    } pol_t;

    localparam int W_DEF       = 12;
    localparam int LOG_WIN_DEF = 4;
    localparam int MIN_AMP_DEF = 64;
    localparam int VC_W_DEF    = 8;

endpackage

// File: rtl/mtrp_peak_win.sv
// Windowed peak/trough tracker; publishes levels and slicing thresholds each window.
// RX_HYST_EN adds a registered mid-level output for hysteresis slicing.
module mtrp_peak_win
    import mtrp_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int LOG_WIN = LOG_WIN_DEF
) (
    input  logic         clk,
    input  logic         res,
    input  logic         ce,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] Inp,
    output logic         win_end,
    output logic [W-2:0] amp_nxt,
    output logic [W-1:0] Xmax,
    output logic [W-1:0] Xmin,
    output logic [W-2:0] AMP,
    output logic [W-1:0] REF_P,
    output logic [W-1:0] REF_N
`ifdef RX_HYST_EN
    ,
    output logic [W-1:0] mid
`endif
);

    logic [LOG_WIN-1:0] cnt;
    logic [W-1:0]       rmax, rmin, smax, smin, diff, mid_nxt, quarter;
    logic [W:0]         sum;

    // Window statistics include the current sample so the last ce of a window counts.
    always_comb begin
        smax    = (Inp > rmax) ? Inp : rmax;
        smin    = (Inp < rmin) ? Inp : rmin;
        diff    = smax - smin;
        sum     = {1'b0, smax} + {1'b0, smin};
        mid_nxt = sum[W:1];
        quarter = {2'b00, diff[W-1:2]};
    end

    assign amp_nxt = diff[W-1:1];
    assign win_end = ce & en & ~clr & (cnt == '1);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt   <= '0;
            rmax  <= '0;
            rmin  <= '1;
            Xmax  <= '0;
            Xmin  <= '0;
            AMP   <= '0;
            REF_P <= '0;
            REF_N <= '0;
        end else if (clr) begin
            cnt  <= '0;
            rmax <= '0;
            rmin <= '1;
        end else if (ce && en) begin
            cnt <= cnt + 1'b1;
            if (win_end) begin
                rmax  <= '0;
                rmin  <= '1;
                Xmax  <= smax;
                Xmin  <= smin;
                AMP   <= amp_nxt;
                REF_P <= mid_nxt + quarter;
                REF_N <= mid_nxt - quarter;
            end else begin
                rmax <= smax;
                rmin <= smin;
            end
        end
    end

`ifdef RX_HYST_EN
    always_ff @(posedge clk or posedge res) begin
        if (res)
            mid <= '0;
        else if (win_end)
            mid <= mid_nxt;
    end
`endif

endmodule

// File: rtl/rx_mtrp_adapt.sv
// Adaptive AMI line receiver: acquisition/lock FSM, mark slicer, bipolar-violation counter.
// Define RX_HYST_EN for hysteresis slicing around the published mid-level.
module rx_mtrp_adapt
    import mtrp_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int LOG_WIN = LOG_WIN_DEF,
    parameter int MIN_AMP = MIN_AMP_DEF,
    parameter int VC_W    = VC_W_DEF
) (
    input  logic            clk,
    input  logic            res,
    input  logic            ce,
    input  logic            st,
    input  logic [W-1:0]    Inp,
    output logic [W-1:0]    Xmax,
    output logic [W-1:0]    Xmin,
    output logic [W-2:0]    AMP,
    output logic [W-1:0]    REF_P,
    output logic [W-1:0]    REF_N,
    output logic            RXP,
    output logic            RXN,
    output logic            Lock,
    output logic [VC_W-1:0] Viol_cnt
);

    localparam logic [W-1:0] MIN_AMP_V = W'(MIN_AMP);

    state_t       state, nxt;
    logic         win_end, amp_ok, slice, p_nxt, n_nxt, mark_p, mark_n, last_vld;
    logic [W-2:0] amp_nxt;
    pol_t         last_pol, pol_new;
`ifdef RX_HYST_EN
    logic [W-1:0] mid;
`endif

    mtrp_peak_win #(.W(W), .LOG_WIN(LOG_WIN)) u_win (
        .clk     (clk),
        .res     (res),
        .ce      (ce),
        .clr     (st),
        .en      (state != ST_IDLE),
        .Inp     (Inp),
        .win_end (win_end),
        .amp_nxt (amp_nxt),
        .Xmax    (Xmax),
        .Xmin    (Xmin),
        .AMP     (AMP),
        .REF_P   (REF_P),
        .REF_N   (REF_N)
`ifdef RX_HYST_EN
        ,
        .mid     (mid)
`endif
    );

    assign amp_ok = {1'b0, amp_nxt} >= MIN_AMP_V;

    always_ff @(posedge clk or posedge res) begin
        if (res)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (st)
            nxt = ST_ACQ;
        else begin
            case (state)
                ST_ACQ:   if (win_end && amp_ok)  nxt = ST_TRACK;
                ST_TRACK: if (win_end && !amp_ok) nxt = ST_ACQ;
                default:  nxt = state;
            endcase
        end
    end

    always_comb begin
        Lock = (state == ST_TRACK);
    end

    always_comb begin
        p_nxt = Inp > REF_P;
        n_nxt = Inp < REF_N;
`ifdef RX_HYST_EN
        if (RXP) p_nxt = Inp > mid;
        if (RXN) n_nxt = Inp < mid;
`endif
        mark_p  = p_nxt & ~RXP;
        mark_n  = n_nxt & ~RXN;
        pol_new = mark_p ? POL_P : POL_N;
        // Losing lock on this edge outranks slicing, so only slice when TRACK persists.
        slice   = (state == ST_TRACK) && (nxt == ST_TRACK);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res || st) begin
            RXP      <= 1'b0;
            RXN      <= 1'b0;
            Viol_cnt <= '0;
            last_vld <= 1'b0;
            last_pol <= POL_P;
        end else if (ce) begin
            if (slice) begin
                RXP <= p_nxt;
                RXN <= n_nxt;
                if (mark_p || mark_n) begin
                    last_vld <= 1'b1;
                    last_pol <= pol_new;
                    if (last_vld && last_pol == pol_new && Viol_cnt != '1)
                        Viol_cnt <= Viol_cnt + 1'b1;
                end
            end else begin
                RXP      <= 1'b0;
                RXN      <= 1'b0;
                last_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx_mtrp_adapt.sv
// Directed bench for rx_mtrp_adapt; a second instance with VC_W=2 covers counter saturation.
module tb_rx_mtrp_adapt;
    import mtrp_pkg::*;

    localparam int W = 12;

    logic          clk = 1'b0, res = 1'b1, ce = 1'b0, st = 1'b0;
    logic [W-1:0]  Inp = '0;
    logic [W-1:0]  Xmax, Xmin, REF_P, REF_N, s_Xmax, s_Xmin, s_REF_P, s_REF_N;
    logic [W-2:0]  AMP, s_AMP;
    logic          RXP, RXN, Lock, s_RXP, s_RXN, s_Lock;
    logic [7:0]    Viol_cnt;
    logic [1:0]    s_Viol_cnt;
    int            n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    rx_mtrp_adapt #(.W(W), .LOG_WIN(4), .MIN_AMP(64), .VC_W(8)) dut (
        .clk(clk), .res(res), .ce(ce), .st(st), .Inp(Inp),
        .Xmax(Xmax), .Xmin(Xmin), .AMP(AMP), .REF_P(REF_P), .REF_N(REF_N),
        .RXP(RXP), .RXN(RXN), .Lock(Lock), .Viol_cnt(Viol_cnt)
    );

    rx_mtrp_adapt #(.W(W), .LOG_WIN(4), .MIN_AMP(64), .VC_W(2)) dut_s (
        .clk(clk), .res(res), .ce(ce), .st(st), .Inp(Inp),
        .Xmax(s_Xmax), .Xmin(s_Xmin), .AMP(s_AMP), .REF_P(s_REF_P), .REF_N(s_REF_N),
        .RXP(s_RXP), .RXN(s_RXN), .Lock(s_Lock), .Viol_cnt(s_Viol_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int v);
        Inp = W'(v);
        tick();
    endtask

    task automatic alt(input int n, input int a, input int b);
        for (int i = 0; i < n; i++) put((i % 2 == 0) ? a : b);
    endtask

    task automatic pulse_st();
        st = 1'b1;
        tick();
        st = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_xmax", 32'(Xmax), 0);
        chk("rst_xmin", 32'(Xmin), 0);
        chk("rst_lock", 32'(Lock), 0);
        chk("rst_rxp", 32'(RXP), 0);
        chk("rst_viol", 32'(Viol_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        res = 1'b0;
        ce  = 1'b1;

        // IDLE ignores samples until st
        alt(20, 3072, 1024);
        chk("idle_xmax", 32'(Xmax), 0);
        chk("idle_lock", 32'(Lock), 0);

        pulse_st();
        alt(15, 3072, 1024);
        chk("w1_pre_xmax", 32'(Xmax), 0);
        chk("w1_pre_lock", 32'(Lock), 0);
        put(1024);
        chk("w1_xmax", 32'(Xmax), 3072);
        chk("w1_xmin", 32'(Xmin), 1024);
        chk("w1_amp", 32'(AMP), 1024);
        chk("w1_refp", 32'(REF_P), 2560);
        chk("w1_refn", 32'(REF_N), 1536);
        chk("w1_lock", 32'(Lock), 1);

        put(3072);
        chk("sl_p_rxp", 32'(RXP), 1);
        chk("sl_p_rxn", 32'(RXN), 0);
        put(1024);
        chk("sl_n_rxp", 32'(RXP), 0);
        chk("sl_n_rxn", 32'(RXN), 1);
        put(2048);
        chk("sl_mid_rxn", 32'(RXN), 0);
        // marks +,+,-,-,+ after the previous '-'
        put(3072); put(2048); put(3072); put(2048);
        put(1024); put(2048); put(1024); put(2048); put(3072);
        chk("viol_2", 32'(Viol_cnt), 2);
        chk("viol_2_s", 32'(s_Viol_cnt), 2);
        repeat (4) put(2048);
        chk("w2_lock", 32'(Lock), 1);

        for (int i = 0; i < 5; i++) begin
            put(3072);
            put(2048);
        end
        chk("viol_7", 32'(Viol_cnt), 7);
        chk("viol_sat", 32'(s_Viol_cnt), 3);
        repeat (6) put(2048);
        chk("w3_amp", 32'(AMP), 512);
        chk("w3_refp", 32'(REF_P), 2816);
        chk("w3_refn", 32'(REF_N), 2304);

        alt(15, 2100, 2000);
        chk("w4_pre_lock", 32'(Lock), 1);
        chk("w4_pre_rxn", 32'(RXN), 1);
        put(2000);
        chk("w4_lock", 32'(Lock), 0);
        chk("w4_rxn", 32'(RXN), 0);
        chk("w4_xmax", 32'(Xmax), 2100);
        chk("w4_amp", 32'(AMP), 50);
        chk("w4_viol", 32'(Viol_cnt), 7);
        alt(16, 2100, 2000);
        chk("w5_lock", 32'(Lock), 0);
        chk("w5_rxp", 32'(RXP), 0);
        chk("w5_rxn", 32'(RXN), 0);

        // sparse ce: junk between strobes must not be absorbed
        pulse_st();
        chk("st_viol_clr", 32'(Viol_cnt), 0);
        for (int i = 0; i < 16; i++) begin
            Inp = (i % 2 == 0) ? W'(3072) : W'(1024);
            ce  = 1'b1;
            tick();
            ce  = 1'b0;
            Inp = W'(4095);
            repeat (3) tick();
            if (i == 14) chk("ce_pre_xmax", 32'(Xmax), 2100);
        end
        chk("ce_xmax", 32'(Xmax), 3072);
        chk("ce_xmin", 32'(Xmin), 1024);
        chk("ce_lock", 32'(Lock), 1);
        Inp = W'(3072);
        ce  = 1'b1;
        tick();
        ce  = 1'b0;
        Inp = W'(1024);
        tick();
        chk("ce_hold_rxp", 32'(RXP), 1);
        chk("ce_hold_rxn", 32'(RXN), 0);
        repeat (2) tick();
        ce = 1'b1;

        pulse_st();
        chk("st_lock", 32'(Lock), 0);
        alt(15, 2100, 2000);
        st = 1'b1;
        put(2000);
        st = 1'b0;
        chk("stwe_xmax", 32'(Xmax), 3072);
        chk("stwe_lock", 32'(Lock), 0);
        alt(15, 2100, 2000);
        chk("stwe_pre_xmax", 32'(Xmax), 3072);
        put(2000);
        chk("stwe_post_xmax", 32'(Xmax), 2100);

        pulse_st();
        alt(16, 3072, 1024);
        chk("r_lock", 32'(Lock), 1);
        put(3072);
        put(1024);
        #2 res = 1'b1;
        #1;
        chk("ares_xmax", 32'(Xmax), 0);
        chk("ares_refp", 32'(REF_P), 0);
        chk("ares_lock", 32'(Lock), 0);
        chk("ares_rxn", 32'(RXN), 0);
        #2 res = 1'b0;
        alt(20, 3072, 1024);
        chk("ares_idle_xmax", 32'(Xmax), 0);
        chk("ares_idle_lock", 32'(Lock), 0);

        pulse_st();
        alt(16, 3072, 1024);
        chk("h_lock", 32'(Lock), 1);
        put(3072);
        chk("h_rxp0", 32'(RXP), 1);
        put(2300);
`ifdef RX_HYST_EN
        chk("h_rxp1", 32'(RXP), 1);
`else
        chk("h_rxp1", 32'(RXP), 0);
`endif
        put(2049);
`ifdef RX_HYST_EN
        chk("h_rxp2", 32'(RXP), 1);
`else
        chk("h_rxp2", 32'(RXP), 0);
`endif
        put(2048);
        chk("h_rxp3", 32'(RXP), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
